// File: rtl/t09_apple_length_controller.sv
// Apple/length game-logic stage behind the snake body controller.
// Build option: T09_SELF_COLLISION_EN enables the head-vs-body compare.
module t09_apple_length_controller #(
  parameter int         MAX_LENGTH  = 50,
  parameter int         INIT_LENGTH = 3,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    start,
  input  logic                    move_pulse,
  input  logic [MAX_LENGTH*8-1:0] body,
  output logic [7:0]              curr_length,
  output logic [7:0]              apple,
  output logic                    eat,
  output logic [1:0]              game_state,
  output logic                    busy
);

  localparam logic [7:0] INIT_LEN = 8'(INIT_LENGTH);
  localparam logic [7:0] MAX_LEN  = 8'(MAX_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_PLACE,
    S_WIN,
    S_LOSE
  } state_t;

  state_t     state, state_nx;
  logic [7:0] lfsr, lfsr_nx;
  logic [7:0] head, head_nx;
  logic [7:0] cand, cand_nx;
  logic [7:0] idx, idx_nx;
  logic [7:0] len_nx;
  logic [7:0] apple_nx;
  logic       eat_nx;
  logic [7:0] seg;
  logic [7:0] len_inc;
  logic       last;
  logic       hit;

  assign lfsr_nx = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Single-segment mux; idx never reaches curr_length, so live segments only.
  always_comb begin
    seg = '0;
    for (int i = 0; i < MAX_LENGTH; i++) begin
      if (idx == 8'(i)) seg = body[8*i +: 8];
    end
  end

  assign last    = (idx == curr_length - 8'd1);
  assign len_inc = curr_length + 8'd1;

`ifdef T09_SELF_COLLISION_EN
  assign hit = (seg == head);
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= S_IDLE;
      lfsr        <= LFSR_SEED;
      head        <= '0;
      cand        <= '0;
      idx         <= '0;
      curr_length <= INIT_LEN;
      apple       <= '0;
      eat         <= 1'b0;
    end else begin
      state       <= state_nx;
      lfsr        <= lfsr_nx;
      head        <= head_nx;
      cand        <= cand_nx;
      idx         <= idx_nx;
      curr_length <= len_nx;
      apple       <= apple_nx;
      eat         <= eat_nx;
    end
  end

  always_comb begin
    state_nx = state;
    head_nx  = head;
    cand_nx  = cand;
    idx_nx   = idx;
    len_nx   = curr_length;
    apple_nx = apple;
    eat_nx   = 1'b0;
    unique case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start) begin
          len_nx   = INIT_LEN;
          cand_nx  = lfsr;
          idx_nx   = '0;
          state_nx = S_PLACE;
        end
      end
      S_RUN: begin
        if (move_pulse) begin
          head_nx  = body[7:0];
          idx_nx   = 8'd1;
          state_nx = S_CHECK;
        end
      end
      S_CHECK: begin
        if (hit) begin
          state_nx = S_LOSE;
        end else if (!last) begin
          idx_nx = idx + 8'd1;
        end else if (head == apple) begin
          eat_nx = 1'b1;
          len_nx = len_inc;
          if (len_inc == MAX_LEN) begin
            state_nx = S_WIN;
          end else begin
            cand_nx  = lfsr;
            idx_nx   = '0;
            state_nx = S_PLACE;
          end
        end else begin
          state_nx = S_RUN;
        end
      end
      S_PLACE: begin
        // Candidate on the body: draw a fresh one and rescan from the head.
        if (seg == cand) begin
          cand_nx = lfsr;
          idx_nx  = '0;
        end else if (last) begin
          apple_nx = cand;
          state_nx = S_RUN;
        end else begin
          idx_nx = idx + 8'd1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    game_state = 2'd1;
    unique case (state)
      S_IDLE:  game_state = 2'd0;
      S_WIN:   game_state = 2'd2;
      S_LOSE:  game_state = 2'd3;
      default: game_state = 2'd1;
    endcase
  end

  assign busy = (state == S_CHECK) || (state == S_PLACE);

endmodule

// File: tb/tb_t09_apple_length_controller.sv
// Directed bench for the apple/length controller.
// Second instance uses MAX_LENGTH=4 to reach WIN.
module tb_t09_apple_length_controller;

  localparam int ML = 50;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start = 1'b0;
  logic          move_pulse = 1'b0;
  logic [ML*8-1:0] body = '0;
  logic [7:0]    curr_length, apple;
  logic          eat, busy;
  logic [1:0]    game_state;

  logic          start4 = 1'b0;
  logic          move4 = 1'b0;
  logic [31:0]   body4 = '0;
  logic [7:0]    len4, apple4;
  logic          eat4, busy4;
  logic [1:0]    gs4;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] a, h;
  int exp_len;

  t09_apple_length_controller #(
    .MAX_LENGTH(ML), .INIT_LENGTH(3), .LFSR_SEED(8'h55)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .move_pulse(move_pulse),
    .body(body), .curr_length(curr_length), .apple(apple), .eat(eat),
    .game_state(game_state), .busy(busy)
  );

  t09_apple_length_controller #(
    .MAX_LENGTH(4), .INIT_LENGTH(3)
  ) dut4 (
    .clk(clk), .nrst(nrst), .start(start4), .move_pulse(move4),
    .body(body4), .curr_length(len4), .apple(apple4), .eat(eat4),
    .game_state(gs4), .busy(busy4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic set_seg(input int i, input logic [7:0] v);
    body[8*i +: 8] = v;
  endtask

  function automatic logic on_body(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      if (body[8*i +: 8] == v) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic wait_idle(input string tag, input bit four);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!(four ? busy4 : busy)) break;
    end
    check(tag, 32'(four ? busy4 : busy), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    check({tag, "_gs"}, 32'(game_state), 32'd0);
    check({tag, "_len"}, 32'(curr_length), 32'd3);
    check({tag, "_apple"}, 32'(apple), 32'd0);
    check({tag, "_eat"}, 32'(eat), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset("rst");
    nrst = 1'b1;
    @(negedge clk);
    move_pulse = 1'b1;
    @(negedge clk);
    move_pulse = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_move_gs", 32'(game_state), 32'd0);
    check("idle_move_len", 32'(curr_length), 32'd3);
    check("idle_move_busy", 32'(busy), 32'd0);

    // start on the first edge after reset so cand is the seed 55
    nrst = 1'b0;
    set_seg(0, 8'h55);
    set_seg(1, 8'h54);
    set_seg(2, 8'h53);
    start = 1'b1;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("place_busy", 32'(busy), 32'd1);
    check("place_gs_run", 32'(game_state), 32'd1);
    wait_idle("place_done", 1'b0);
    check("place_gs", 32'(game_state), 32'd1);
    check("place_not_seed", 32'(apple == 8'h55), 32'd0);
    check("place_off_body", 32'(on_body(apple, 3)), 32'd0);
    check("place_nonzero", 32'(apple == 8'h00), 32'd0);

    // eat with len 3; a second pulse inside CHECK is dropped
    a = apple;
    set_seg(0, a);
    set_seg(1, a ^ 8'h01);
    set_seg(2, a ^ 8'h02);
    set_seg(3, a ^ 8'h03);
    move_pulse = 1'b1;
    @(negedge clk);
    move_pulse = 1'b0;
    check("chk_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("eat_early", 32'(eat), 32'd0);
    move_pulse = 1'b1;
    @(negedge clk);
    move_pulse = 1'b0;
    check("eat_pulse", 32'(eat), 32'd1);
    check("eat_len", 32'(curr_length), 32'd4);
    @(negedge clk);
    check("eat_once", 32'(eat), 32'd0);
    wait_idle("grow_place", 1'b0);
    check("grow_len", 32'(curr_length), 32'd4);
    check("grow_gs", 32'(game_state), 32'd1);
    check("grow_off_body", 32'(on_body(apple, 4)), 32'd0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("run_start_busy", 32'(busy), 32'd0);
    check("run_start_len", 32'(curr_length), 32'd4);

    // miss with len 4: exits to RUN on the 4th edge
    a = apple;
    set_seg(0, a ^ 8'h10);
    set_seg(1, a ^ 8'h11);
    set_seg(2, a ^ 8'h12);
    set_seg(3, a ^ 8'h13);
    move_pulse = 1'b1;
    @(negedge clk);
    move_pulse = 1'b0;
    repeat (2) @(negedge clk);
    check("miss_busy3", 32'(busy), 32'd1);
    @(negedge clk);
    check("miss_busy4", 32'(busy), 32'd0);
    check("miss_eat", 32'(eat), 32'd0);
    check("miss_len", 32'(curr_length), 32'd4);

    // head repeats at the last live segment
    h = (apple == 8'h44) ? 8'h33 : 8'h44;
    set_seg(0, h);
    set_seg(1, h + 8'd1);
    set_seg(2, h + 8'd2);
    set_seg(3, h);
    move_pulse = 1'b1;
    @(negedge clk);
    move_pulse = 1'b0;
    repeat (2) @(negedge clk);
    check("col_gs3", 32'(game_state), 32'd1);
    @(negedge clk);
`ifdef T09_SELF_COLLISION_EN
    check("col_gs", 32'(game_state), 32'd3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lose_restart_len", 32'(curr_length), 32'd3);
    wait_idle("lose_restart", 1'b0);
    check("lose_restart_gs", 32'(game_state), 32'd1);
    exp_len = 3;
`else
    check("col_gs", 32'(game_state), 32'd1);
    check("col_busy", 32'(busy), 32'd0);
    exp_len = 4;
`endif

    // eat, then reset while PLACE is running
    a = apple;
    set_seg(0, a);
    set_seg(1, a ^ 8'h01);
    set_seg(2, a ^ 8'h02);
    set_seg(3, a ^ 8'h03);
    move_pulse = 1'b1;
    @(negedge clk);
    move_pulse = 1'b0;
    repeat (exp_len - 1) @(negedge clk);
    check("eat2_pulse", 32'(eat), 32'd1);
    check("eat2_len", 32'(curr_length), 32'(exp_len + 1));
    check("eat2_busy", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    chk_reset("abort");
    @(negedge clk);
    check("abort_hold_gs", 32'(game_state), 32'd0);
    check("abort_hold_busy", 32'(busy), 32'd0);
    nrst = 1'b1;

    // MAX_LENGTH=4 instance reaches WIN
    @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_idle("d4_place", 1'b1);
    check("d4_run", 32'(gs4), 32'd1);
    a = apple4;
    body4 = {8'h00, a ^ 8'h02, a ^ 8'h01, a};
    move4 = 1'b1;
    @(negedge clk);
    move4 = 1'b0;
    repeat (2) @(negedge clk);
    check("d4_eat", 32'(eat4), 32'd1);
    check("d4_len", 32'(len4), 32'd4);
    check("d4_win", 32'(gs4), 32'd2);
    check("d4_busy", 32'(busy4), 32'd0);
    move4 = 1'b1;
    @(negedge clk);
    move4 = 1'b0;
    @(negedge clk);
    check("d4_win_len", 32'(len4), 32'd4);
    check("d4_win_gs", 32'(gs4), 32'd2);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    check("d4_restart_len", 32'(len4), 32'd3);
    check("d4_restart_gs", 32'(gs4), 32'd1);
    wait_idle("d4_replace", 1'b1);
    check("d4_rerun", 32'(gs4), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
